// File: rtl/rshift_fastshift_ctrl.sv
// Fastshift sequencer: left-aligns a short frame in the receive shift register by
// strobing zero-shifts at clock/2 once the MAC FSM has stopped normal shifting.
module rshift_fastshift_ctrl #(
    parameter int unsigned DATA_BITS = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] dlc,
    input  logic       abort,
    output logic       directshift,
    output logic       setzero,
    output logic       busy,
    output logic       done,
    output logic [6:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_SETTLE,
        S_DONE
    } state_e;

    localparam logic [3:0] MAX_BYTES = 4'(DATA_BITS / 8);

    state_e     state_q, state_d;
    logic       directshift_q, directshift_d;
    logic       setzero_q, setzero_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [6:0] remaining_q, remaining_d;

    logic [3:0] dlc_sat;
    logic [6:0] shift_count;

    // Saturate at the field size so narrower fields never yield a negative count.
    always_comb begin
        dlc_sat     = (dlc > MAX_BYTES) ? MAX_BYTES : dlc;
        shift_count = 7'(DATA_BITS) - {dlc_sat, 3'b000};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            directshift_q <= 1'b0;
            setzero_q     <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            remaining_q   <= '0;
        end else begin
            state_q       <= state_d;
            directshift_q <= directshift_d;
            setzero_q     <= setzero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            remaining_q   <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    remaining_d = shift_count;
                    state_d     = (shift_count == '0) ? S_DONE : S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                state_d     = S_SHIFT_LO;
                remaining_d = remaining_q - 7'd1;
            end
            S_SHIFT_LO: state_d = (remaining_q != '0) ? S_SHIFT_HI : S_SETTLE;
            S_SETTLE:   state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            remaining_d = '0;
        end
    end

    // Outputs are decoded from the next state so the registered values line up
    // with the state occupied during the following cycle.
    always_comb begin
        directshift_d = 1'b0;
        setzero_d     = 1'b1;
        busy_d        = 1'b1;
        done_d        = 1'b0;
        case (state_d)
            S_IDLE:     busy_d = 1'b0;
            S_SHIFT_HI: begin
                directshift_d = 1'b1;
                setzero_d     = 1'b0;
            end
            S_SHIFT_LO: setzero_d = 1'b0;
            S_SETTLE:   setzero_d = 1'b0;
            S_DONE:     done_d = 1'b1;
            default:    busy_d = 1'b0;
        endcase
    end

    assign directshift = directshift_q;
    assign setzero     = setzero_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign remaining   = remaining_q;

endmodule
